// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory
// handshakes, timeout and illegal-opcode traps, and a retired-instruction counter.
module multicycle_control #(
    parameter int OPCODE_W = 11,
    parameter int ALUOP_W  = 4,
    parameter int TIMEOUT  = 16,
    parameter int COUNT_W  = 32
) (
    input  logic                Clk,
    input  logic                Reset_L,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    input  logic                zero,
    output logic                imem_req,
    output logic                ir_write,
    output logic                pc_write,
    output logic                reg2loc,
    output logic                alusrc,
    output logic                mem2reg,
    output logic                regwrite,
    output logic                memread,
    output logic                memwrite,
    output logic                branch,
    output logic                uncond_branch,
    output logic                zornz,
    output logic [ALUOP_W-1:0]  aluop,
    output logic [2:0]          signop,
    output logic [2:0]          state,
    output logic [1:0]          trap_cause,
    output logic [COUNT_W-1:0]  retired
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        C_ILL, C_AND, C_ORR, C_ADD, C_SUB, C_ADDI, C_SUBI,
        C_MOVZ, C_LDUR, C_STUR, C_B, C_CBZ, C_CBNZ
    } cls_e;

    function automatic cls_e classify(input logic [10:0] op);
        cls_e c;
        casez (op)
            11'b11111000010: c = C_LDUR;
            11'b11111000000: c = C_STUR;
            11'b10001011000: c = C_ADD;
            11'b11001011000: c = C_SUB;
            11'b10001010000: c = C_AND;
            11'b10101010000: c = C_ORR;
            11'b10110100???: c = C_CBZ;
            11'b10110101???: c = C_CBNZ;
            11'b000101?????: c = C_B;
            11'b1001000100?: c = C_ADDI;
            11'b1101000100?: c = C_SUBI;
            11'b110100101??: c = C_MOVZ;
            default:         c = C_ILL;
        endcase
        return c;
    endfunction

    state_e                state_q, state_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [OPCODE_W-1:0]   op_q, op_d;
    logic [1:0]            trap_q, trap_d;
    logic [COUNT_W-1:0]    retired_q, retired_d;
    cls_e                  dec_cls, cur_cls;
    logic                  retire;
    logic                  wait_expired;

    assign dec_cls      = classify(opcode[10:0]);
    assign cur_cls      = classify(op_q[10:0]);
    assign wait_expired = (wait_q == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge Clk) begin
        if (!Reset_L) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            op_q      <= '0;
            trap_q    <= 2'b00;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            op_q      <= op_d;
            trap_q    <= trap_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        op_d    = op_q;
        trap_d  = trap_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_DECODE;
                    wait_d  = '0;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                    trap_d  = 2'b10;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (dec_cls == C_ILL) begin
                    state_d = S_TRAP;
                    trap_d  = 2'b01;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cur_cls)
                    C_B, C_CBZ, C_CBNZ: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    C_LDUR, C_STUR: state_d = S_MEM;
                    default:        state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    wait_d = '0;
                    if (cur_cls == C_LDUR) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                    trap_d  = 2'b10;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP: state_d = S_TRAP;
            // Unused encodings recover to a clean fetch.
            default: begin
                state_d = S_FETCH;
                wait_d  = '0;
            end
        endcase
        retired_d = retire ? retired_q + COUNT_W'(1) : retired_q;
    end

    always_comb begin
        imem_req      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg2loc       = 1'b0;
        alusrc        = 1'b0;
        mem2reg       = 1'b0;
        regwrite      = 1'b0;
        memread       = 1'b0;
        memwrite      = 1'b0;
        branch        = 1'b0;
        uncond_branch = 1'b0;
        zornz         = 1'b0;
        aluop         = '0;
        signop        = 3'b000;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                pc_write = imem_ready;
            end
            S_EXEC: begin
                case (cur_cls)
                    C_AND:  aluop = ALUOP_W'(4'b0000);
                    C_ORR:  aluop = ALUOP_W'(4'b0001);
                    C_ADD:  aluop = ALUOP_W'(4'b0010);
                    C_SUB:  aluop = ALUOP_W'(4'b0110);
                    C_ADDI: begin aluop = ALUOP_W'(4'b0010); alusrc = 1'b1; end
                    C_SUBI: begin aluop = ALUOP_W'(4'b0110); alusrc = 1'b1; end
                    C_MOVZ: begin aluop = ALUOP_W'(4'b1000); alusrc = 1'b1; signop = 3'b100; end
                    C_LDUR: begin aluop = ALUOP_W'(4'b0010); alusrc = 1'b1; signop = 3'b001; end
                    C_STUR: begin
                        aluop   = ALUOP_W'(4'b0010);
                        alusrc  = 1'b1;
                        reg2loc = 1'b1;
                        signop  = 3'b001;
                    end
                    C_B: begin
                        uncond_branch = 1'b1;
                        pc_write      = 1'b1;
                        signop        = 3'b010;
                    end
                    C_CBZ, C_CBNZ: begin
                        aluop    = ALUOP_W'(4'b0111);
                        reg2loc  = 1'b1;
                        signop   = 3'b011;
                        branch   = 1'b1;
                        zornz    = (cur_cls == C_CBZ);
                        pc_write = (cur_cls == C_CBZ) ? zero : ~zero;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                alusrc   = 1'b1;
                aluop    = ALUOP_W'(4'b0010);
                memread  = (cur_cls == C_LDUR);
                memwrite = (cur_cls == C_STUR);
            end
            S_WB: begin
                regwrite = 1'b1;
                mem2reg  = (cur_cls == C_LDUR);
            end
            default: ;
        endcase
    end

    assign state      = state_q;
    assign trap_cause = trap_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, randomized instruction stream
// against a per-instruction phase model, and hand-built trap/timeout/reset sequences.
module tb_multicycle_control;

    localparam int TO = 4;
    localparam int CW = 4;

    logic          Clk = 1'b0;
    logic          Reset_L = 1'b0;
    logic [10:0]   opcode = '0;
    logic          imem_ready = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          zero = 1'b0;
    logic          imem_req, ir_write, pc_write, reg2loc, alusrc, mem2reg, regwrite;
    logic          memread, memwrite, branch, uncond_branch, zornz;
    logic [3:0]    aluop;
    logic [2:0]    signop;
    logic [2:0]    state;
    logic [1:0]    trap_cause;
    logic [CW-1:0] retired;

    multicycle_control #(
        .OPCODE_W(11), .ALUOP_W(4), .TIMEOUT(TO), .COUNT_W(CW)
    ) dut (
        .Clk(Clk), .Reset_L(Reset_L), .opcode(opcode),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .zero(zero),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
        .reg2loc(reg2loc), .alusrc(alusrc), .mem2reg(mem2reg), .regwrite(regwrite),
        .memread(memread), .memwrite(memwrite), .branch(branch),
        .uncond_branch(uncond_branch), .zornz(zornz), .aluop(aluop), .signop(signop),
        .state(state), .trap_cause(trap_cause), .retired(retired)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       imem_req, ir_write, pc_write, reg2loc, alusrc, mem2reg, regwrite;
        logic       memread, memwrite, branch, uncond_branch, zornz;
        logic [3:0] aluop;
        logic [2:0] signop;
    } ctrl_t;

    typedef struct {
        logic          rl, im, dm, z;
        logic [10:0]   op;
        logic          chk;
        logic [2:0]    st;
        ctrl_t         ctl;
        logic [1:0]    tc;
        logic [CW-1:0] ret;
    } vec_t;

    ctrl_t act_ctl;
    assign act_ctl = {imem_req, ir_write, pc_write, reg2loc, alusrc, mem2reg, regwrite,
                      memread, memwrite, branch, uncond_branch, zornz, aluop, signop};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_no   = 0;
    int model_ret = 0;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_CBNZ = 11'b10110101011;
    localparam logic [10:0] OP_B    = 11'b00010100011;

    function automatic ctrl_t k(input logic ir, irw, pcw, r2l, asrc, m2r, rw, mr, mw,
                                input logic br, ub, zn, input logic [3:0] ao,
                                input logic [2:0] so);
        ctrl_t c;
        c = {ir, irw, pcw, r2l, asrc, m2r, rw, mr, mw, br, ub, zn, ao, so};
        return c;
    endfunction

    function automatic vec_t mk(input logic rl, im, dm, z, input logic [10:0] op,
                                input logic chk, input logic [2:0] st, input ctrl_t ctl,
                                input logic [1:0] tc, input int ret);
        vec_t v;
        v.rl = rl; v.im = im; v.dm = dm; v.z = z; v.op = op; v.chk = chk;
        v.st = st; v.ctl = ctl; v.tc = tc; v.ret = CW'(ret);
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h, want %h", nm, cyc_no, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge Clk);
        cyc_no++;
        Reset_L    = v.rl;
        imem_ready = v.im;
        dmem_ready = v.dm;
        zero       = v.z;
        opcode     = v.op;
        #1;
        if (v.chk) begin
            check("state", 32'(state), 32'(v.st));
            check("ctrl", 32'(act_ctl), 32'(v.ctl));
            check("trap_cause", 32'(trap_cause), 32'(v.tc));
            check("retired", 32'(retired), 32'(v.ret));
        end
    endtask

    // Instruction kinds: base opcode, don't-care bits, and the EXEC-phase controls.
    function automatic void info(input int kd, output logic [10:0] base,
                                 output logic [10:0] mask, output ctrl_t ex);
        mask = '0;
        case (kd)
            0:  begin base = 11'b10001011000; ex = k(0,0,0,0,0,0,0,0,0,0,0,0,4'b0010,3'b000); end
            1:  begin base = 11'b11001011000; ex = k(0,0,0,0,0,0,0,0,0,0,0,0,4'b0110,3'b000); end
            2:  begin base = 11'b10001010000; ex = k(0,0,0,0,0,0,0,0,0,0,0,0,4'b0000,3'b000); end
            3:  begin base = 11'b10101010000; ex = k(0,0,0,0,0,0,0,0,0,0,0,0,4'b0001,3'b000); end
            4:  begin base = 11'b10010001000; mask = 11'b00000000001;
                      ex = k(0,0,0,0,1,0,0,0,0,0,0,0,4'b0010,3'b000); end
            5:  begin base = 11'b11010001000; mask = 11'b00000000001;
                      ex = k(0,0,0,0,1,0,0,0,0,0,0,0,4'b0110,3'b000); end
            6:  begin base = 11'b11010010100; mask = 11'b00000000011;
                      ex = k(0,0,0,0,1,0,0,0,0,0,0,0,4'b1000,3'b100); end
            7:  begin base = OP_LDUR; ex = k(0,0,0,0,1,0,0,0,0,0,0,0,4'b0010,3'b001); end
            8:  begin base = OP_STUR; ex = k(0,0,0,1,1,0,0,0,0,0,0,0,4'b0010,3'b001); end
            9:  begin base = 11'b00010100000; mask = 11'b00000011111;
                      ex = k(0,0,1,0,0,0,0,0,0,0,1,0,4'b0000,3'b010); end
            10: begin base = 11'b10110100000; mask = 11'b00000000111;
                      ex = k(0,0,0,1,0,0,0,0,0,1,0,1,4'b0111,3'b011); end
            default: begin base = 11'b10110101000; mask = 11'b00000000111;
                      ex = k(0,0,0,1,0,0,0,0,0,1,0,0,4'b0111,3'b011); end
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic retire_one();
        model_ret = (model_ret + 1) % (1 << CW);
    endtask

    // One instruction walked phase by phase; iw/dw are the memory wait cycles.
    task automatic run_instr(input int kd, input int iw, input int dw);
        logic [10:0] base, mask, op;
        ctrl_t ex, c;
        logic z;
        info(kd, base, mask, ex);
        op = base | (11'($urandom) & mask);
        for (int i = 0; i <= iw; i++) begin
            logic im;
            im = (i == iw);
            apply(mk(1, im, rb(), rb(), 11'($urandom), 1, 3'd0,
                     k(1,im,im,0,0,0,0,0,0,0,0,0,4'h0,3'h0), 2'b00, model_ret));
        end
        apply(mk(1, rb(), rb(), rb(), op, 1, 3'd1, '0, 2'b00, model_ret));
        z = rb();
        c = ex;
        if (kd == 10) c.pc_write = z;
        if (kd == 11) c.pc_write = ~z;
        apply(mk(1, rb(), rb(), z, 11'($urandom), 1, 3'd2, c, 2'b00, model_ret));
        if (kd >= 9) begin
            retire_one();
            return;
        end
        if (kd == 7 || kd == 8) begin
            for (int j = 0; j <= dw; j++) begin
                logic dm;
                dm = (j == dw);
                apply(mk(1, rb(), dm, rb(), 11'($urandom), 1, 3'd3,
                         k(0,0,0,0,1,0,0,(kd == 7),(kd == 8),0,0,0,4'b0010,3'h0),
                         2'b00, model_ret));
            end
            if (kd == 8) begin
                retire_one();
                return;
            end
        end
        apply(mk(1, rb(), rb(), rb(), 11'($urandom), 1, 3'd4,
                 k(0,0,0,0,0,(kd == 7),1,0,0,0,0,0,4'h0,3'h0), 2'b00, model_ret));
        retire_one();
    endtask

    vec_t  tbl[21];
    ctrl_t f_rdy, f_idle, c_mem_ld, c_mem_st;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        f_rdy    = k(1,1,1,0,0,0,0,0,0,0,0,0,4'h0,3'h0);
        f_idle   = k(1,0,0,0,0,0,0,0,0,0,0,0,4'h0,3'h0);
        c_mem_ld = k(0,0,0,0,1,0,0,1,0,0,0,0,4'b0010,3'h0);
        c_mem_st = k(0,0,0,0,1,0,0,0,1,0,0,0,4'b0010,3'h0);

        // ADD, LDUR with three dmem wait cycles, CBZ/CBNZ with zero=1, B.
        tbl[0]  = mk(1,1,1,0,OP_ADD,1,0,f_rdy,0,0);
        tbl[1]  = mk(1,1,1,0,OP_ADD,1,1,'0,0,0);
        tbl[2]  = mk(1,1,1,0,OP_ADD,1,2,k(0,0,0,0,0,0,0,0,0,0,0,0,4'b0010,3'b000),0,0);
        tbl[3]  = mk(1,1,1,0,OP_ADD,1,4,k(0,0,0,0,0,0,1,0,0,0,0,0,4'h0,3'h0),0,0);
        tbl[4]  = mk(1,1,0,0,OP_LDUR,1,0,f_rdy,0,1);
        tbl[5]  = mk(1,0,0,0,OP_LDUR,1,1,'0,0,1);
        tbl[6]  = mk(1,1,0,0,11'h0,1,2,k(0,0,0,0,1,0,0,0,0,0,0,0,4'b0010,3'b001),0,1);
        tbl[7]  = mk(1,1,0,0,11'h0,1,3,c_mem_ld,0,1);
        tbl[8]  = mk(1,1,0,0,11'h0,1,3,c_mem_ld,0,1);
        tbl[9]  = mk(1,1,0,0,11'h0,1,3,c_mem_ld,0,1);
        tbl[10] = mk(1,1,1,0,11'h0,1,3,c_mem_ld,0,1);
        tbl[11] = mk(1,0,0,0,11'h0,1,4,k(0,0,0,0,0,1,1,0,0,0,0,0,4'h0,3'h0),0,1);
        tbl[12] = mk(1,1,0,1,OP_CBZ,1,0,f_rdy,0,2);
        tbl[13] = mk(1,0,0,1,OP_CBZ,1,1,'0,0,2);
        tbl[14] = mk(1,0,0,1,OP_CBZ,1,2,k(0,0,1,1,0,0,0,0,0,1,0,1,4'b0111,3'b011),0,2);
        tbl[15] = mk(1,1,0,1,OP_CBNZ,1,0,f_rdy,0,3);
        tbl[16] = mk(1,0,0,1,OP_CBNZ,1,1,'0,0,3);
        tbl[17] = mk(1,0,0,1,OP_CBNZ,1,2,k(0,0,0,1,0,0,0,0,0,1,0,0,4'b0111,3'b011),0,3);
        tbl[18] = mk(1,1,0,0,OP_B,1,0,f_rdy,0,4);
        tbl[19] = mk(1,0,0,0,OP_B,1,1,'0,0,4);
        tbl[20] = mk(1,0,0,0,OP_B,1,2,k(0,0,1,0,0,0,0,0,0,0,1,0,4'h0,3'b010),0,4);

        apply(mk(0,0,0,0,11'h0,0,0,'0,0,0));
        apply(mk(0,0,0,0,11'h0,0,0,'0,0,0));
        for (int i = 0; i < 21; i++) apply(tbl[i]);
        model_ret = 5;

        // Random stream; wait counts up to TIMEOUT-1 exercise the last-chance ready.
        for (int n = 0; n < 60; n++)
            run_instr(int'($urandom_range(0, 11)), int'($urandom_range(0, TO - 1)),
                      int'($urandom_range(0, TO - 1)));

        // Illegal opcode traps after DECODE and holds until reset.
        apply(mk(1,1,rb(),0,11'($urandom),1,0,f_rdy,0,model_ret));
        apply(mk(1,rb(),rb(),0,11'h000,1,1,'0,0,model_ret));
        for (int i = 0; i < 12; i++)
            apply(mk(1,rb(),rb(),rb(),11'($urandom),1,7,'0,2'b01,model_ret));
        apply(mk(0,0,0,0,11'h0,1,7,'0,2'b01,model_ret));
        model_ret = 0;

        // Fetch timeout: four FETCH cycles without imem_ready, then TRAP.
        for (int i = 0; i < TO; i++)
            apply(mk(1,0,rb(),rb(),11'($urandom),1,0,f_idle,0,0));
        for (int i = 0; i < 3; i++)
            apply(mk(1,rb(),rb(),rb(),11'($urandom),1,7,'0,2'b10,0));
        apply(mk(0,0,0,0,11'h0,1,7,'0,2'b10,0));

        // Reset landing in MEM during STUR.
        apply(mk(1,1,0,0,OP_STUR,1,0,f_rdy,0,0));
        apply(mk(1,0,0,0,OP_STUR,1,1,'0,0,0));
        apply(mk(1,0,0,0,11'h0,1,2,k(0,0,0,1,1,0,0,0,0,0,0,0,4'b0010,3'b001),0,0));
        apply(mk(1,0,0,0,11'h0,1,3,c_mem_st,0,0));
        apply(mk(0,0,0,0,11'h0,1,3,c_mem_st,0,0));
        apply(mk(1,0,0,0,11'h0,1,0,f_idle,0,0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
